usp_id_route_decoder: RTL

//  Consumes the USP bus numbers (primary/secondary/subordinate plus all-ready flag) produced by the
//  ext-config bus-number snoop and classifies ID-routed TLP headers arriving from the USP toward the
//  DSP: CfgRd/CfgWr Type1 and Cpl/CplD. Two-stage registered pipeline with valid/ready handshake.
//  Its output drives the switch forwarding mux, including Type1->Type0 conversion and UR generation.

---
 rtl/usp_id_route_decoder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/usp_id_route_decoder.sv
// Classifies ID-routed TLP headers (Cfg Type1, Cpl*) arriving from the USP against the
// snooped secondary/subordinate bus numbers; two-stage valid/ready pipeline.
module usp_id_route_decoder #(
  parameter int USER_W = 32
) (
  input  logic              usp_user_clk,
  input  logic              sys_reset_n,
  input  logic              usp_user_reset,
  input  logic [7:0]        usp_sec_bus,
  input  logic [7:0]        usp_sub_bus,
  input  logic              all_bus_numbers_ready,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_fmt_type,
  input  logic [15:0]       s_target_id,
  input  logic [USER_W-1:0] s_user,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [1:0]        m_route,
  output logic              m_convert_type0,
  output logic [USER_W-1:0] m_user,
  output logic [15:0]       ur_count
);

  localparam logic [1:0] ROUTE_FWD_DSP   = 2'b00;
  localparam logic [1:0] ROUTE_CFG_LOCAL = 2'b01;
  localparam logic [1:0] ROUTE_UR        = 2'b10;

  logic              r_v1;
  logic [7:0]        r_fmt1;
  logic [4:0]        r_dev1;
  logic              r_inSec1;
  logic              r_inRange1;
  logic [USER_W-1:0] r_user1;

  logic              r_v2;
  logic [1:0]        r_route2;
  logic              r_conv2;
  logic [USER_W-1:0] r_user2;
  logic [15:0]       r_urCount;

  logic              w_adv2;
  logic              w_accept;
  logic [7:0]        w_bus;
  logic              w_inSec;
  logic              w_inRange;
  logic [1:0]        w_route;
  logic              w_conv;
  logic              w_outFire;
  logic [2:0]        w_unusedFn;

  assign w_adv2     = ~r_v2 | m_ready;
  assign s_ready    = all_bus_numbers_ready & (~r_v1 | w_adv2);
  assign w_accept   = s_valid & s_ready;
  assign w_bus      = s_target_id[15:8];
  assign w_unusedFn = s_target_id[2:0];
  assign w_inSec    = (w_bus == usp_sec_bus);
  // With sec > sub this is naturally empty, so misprogramming needs no special case.
  assign w_inRange  = (w_bus > usp_sec_bus) & (w_bus <= usp_sub_bus);
  assign w_outFire  = r_v2 & m_ready;

  always_comb begin
    w_route = ROUTE_UR;
    w_conv  = 1'b0;
    case (r_fmt1)
      8'h05, 8'h45: begin
        if (r_inSec1) begin
          if (r_dev1 == 5'd0) begin
            w_route = ROUTE_CFG_LOCAL;
            w_conv  = 1'b1;
          end else begin
            w_route = ROUTE_UR;
          end
        end else if (r_inRange1) begin
          w_route = ROUTE_FWD_DSP;
        end
      end
      8'h0A, 8'h4A, 8'h0B, 8'h4B: begin
        if (r_inSec1 | r_inRange1) w_route = ROUTE_FWD_DSP;
      end
      default: w_route = ROUTE_UR;
    endcase
  end

  always_ff @(posedge usp_user_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_v1       <= 1'b0;
      r_fmt1     <= '0;
      r_dev1     <= '0;
      r_inSec1   <= 1'b0;
      r_inRange1 <= 1'b0;
      r_user1    <= '0;
    end else if (usp_user_reset) begin
      r_v1       <= 1'b0;
      r_fmt1     <= '0;
      r_dev1     <= '0;
      r_inSec1   <= 1'b0;
      r_inRange1 <= 1'b0;
      r_user1    <= '0;
    end else if (~r_v1 | w_adv2) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_fmt1     <= s_fmt_type;
        r_dev1     <= s_target_id[7:3];
        r_inSec1   <= w_inSec;
        r_inRange1 <= w_inRange;
        r_user1    <= s_user;
      end
    end
  end

  // Output register only reloads when empty or drained, which holds it stable under stall.
  always_ff @(posedge usp_user_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_v2     <= 1'b0;
      r_route2 <= ROUTE_FWD_DSP;
      r_conv2  <= 1'b0;
      r_user2  <= '0;
    end else if (usp_user_reset) begin
      r_v2     <= 1'b0;
      r_route2 <= ROUTE_FWD_DSP;
      r_conv2  <= 1'b0;
      r_user2  <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_route2 <= w_route;
        r_conv2  <= w_conv;
        r_user2  <= r_user1;
      end
    end
  end

  always_ff @(posedge usp_user_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_urCount <= '0;
    end else if (usp_user_reset) begin
      r_urCount <= '0;
    end else if (w_outFire && (r_route2 == ROUTE_UR) && (r_urCount != 16'hFFFF)) begin
      r_urCount <= r_urCount + 16'd1;
    end
  end

  assign m_valid         = r_v2;
  assign m_route         = r_route2;
  assign m_convert_type0 = r_conv2;
  assign m_user          = r_user2;
  assign ur_count        = r_urCount;

endmodule
